// File: rtl/clk_div_pkg.sv
// Shared constants and the ratio clamp used by the programmable clock dividers.
package clk_div_pkg;

  localparam int unsigned RatioMin = 2;
  localparam int unsigned DefDivW  = 4;
  localparam int unsigned DefRatio = 4;

  function automatic int unsigned ratio_clamp(input int unsigned ratio);
    return (ratio < RatioMin) ? RatioMin : ratio;
  endfunction

endpackage

// File: rtl/clk_div_n_if.sv
// Control and status bundle of clk_div_n; the divider itself sits on the slave side.
interface clk_div_n_if
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned CNT_W = 2
);

  logic             en;
  logic [DIV_W-1:0] div_ratio;
  logic             load;
  logic             clk_div;
  logic             rise_tick;
  logic [CNT_W-1:0] po_cnt;
  logic             pend;

  modport master (
    output en, div_ratio, load,
    input  clk_div, rise_tick, po_cnt, pend
  );

  modport slave (
    input  en, div_ratio, load,
    output clk_div, rise_tick, po_cnt, pend
  );

endinterface

// File: rtl/wrap_cnt.sv
// Enable-driven counter that runs 0..CNT_MAX and wraps back to 0.
module wrap_cnt #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned CNT_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = (cnt_q == CNT_W'(CNT_MAX)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer divider: registered divided level, rise tick and period count.
// Ratio changes are shadowed and only take effect on a period boundary or while parked.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W     = DefDivW,
  parameter int unsigned DEF_RATIO = DefRatio,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned CNT_MAX   = 3
) (
  input logic        clk,
  input logic        rst_n,
  clk_div_n_if.slave bus
);

  logic [DIV_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_ratio_q, pend_ratio_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             rise_tick_q, rise_tick_d;
  logic [DIV_W-1:0] ph_nxt;
  logic             boundary;

  always_comb begin
    ph_cnt_d     = ph_cnt_q;
    n_d          = n_q;
    pend_d       = pend_q;
    pend_ratio_d = pend_ratio_q;
    clk_div_d    = 1'b0;
    rise_tick_d  = 1'b0;
    boundary     = (ph_cnt_q == n_q - DIV_W'(1));
    ph_nxt       = boundary ? '0 : ph_cnt_q + DIV_W'(1);

    if (bus.en) begin
      ph_cnt_d    = ph_nxt;
      clk_div_d   = (ph_nxt >= (n_q >> 1));
      rise_tick_d = clk_div_d & ~clk_div_q;
    end else begin
      ph_cnt_d = '0;
    end

    // A parked divider has no period to protect, so the shadow ratio applies at once.
    if (pend_q && (boundary || !bus.en)) begin
      n_d    = pend_ratio_q;
      pend_d = 1'b0;
    end

    // Load after the apply step: a load in the boundary cycle waits for the next boundary.
    if (bus.load) begin
      pend_ratio_d = DIV_W'(ratio_clamp(32'(bus.div_ratio)));
      pend_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt_q     <= '0;
      n_q          <= DIV_W'(DEF_RATIO);
      pend_ratio_q <= DIV_W'(DEF_RATIO);
      pend_q       <= 1'b0;
      clk_div_q    <= 1'b0;
      rise_tick_q  <= 1'b0;
    end else begin
      ph_cnt_q     <= ph_cnt_d;
      n_q          <= n_d;
      pend_ratio_q <= pend_ratio_d;
      pend_q       <= pend_d;
      clk_div_q    <= clk_div_d;
      rise_tick_q  <= rise_tick_d;
    end
  end

  wrap_cnt #(
    .CNT_W  (CNT_W),
    .CNT_MAX(CNT_MAX)
  ) u_po_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rise_tick_q),
    .cnt  (bus.po_cnt)
  );

  assign bus.clk_div   = clk_div_q;
  assign bus.rise_tick = rise_tick_q;
  assign bus.pend      = pend_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: default 4-bit divider plus an 8-bit instance for long periods.
module tb_clk_div_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  clk_div_n_if #(.DIV_W(4), .CNT_W(2)) bus4 ();
  clk_div_n_if #(.DIV_W(8), .CNT_W(3)) bus8 ();

  clk_div_n #(
    .DIV_W    (4),
    .DEF_RATIO(4),
    .CNT_W    (2),
    .CNT_MAX  (3)
  ) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  clk_div_n #(
    .DIV_W    (8),
    .DEF_RATIO(4),
    .CNT_W    (3),
    .CNT_MAX  (5)
  ) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus4.en = 1'b0; bus4.load = 1'b0; bus4.div_ratio = '0;
    bus8.en = 1'b0; bus8.load = 1'b0; bus8.div_ratio = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_div", 32'(bus4.clk_div), 0);
    chk("rst_rise", 32'(bus4.rise_tick), 0);
    chk("rst_po", 32'(bus4.po_cnt), 0);
    chk("rst_pend", 32'(bus4.pend), 0);
    chk("rst_ratio", 32'(dut4.n_q), 4);
    chk("rst_ph", 32'(dut4.ph_cnt_q), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: default N=4, 16 cycles
    bus4.en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      chk("t1_clk_div", 32'(bus4.clk_div), 32'(c % 4 >= 2));
      chk("t1_rise", 32'(bus4.rise_tick), 32'(c % 4 == 2));
      chk("t1_po", 32'(bus4.po_cnt), 32'(((c + 1) / 4) % 4));
      tick();
    end

    // 2: load 5 mid-period, current period completes
    tick();
    bus4.load = 1'b1; bus4.div_ratio = 4'd5;
    tick();
    bus4.load = 1'b0;
    chk("t2_pend_a", 32'(bus4.pend), 1);
    chk("t2_rise_old", 32'(bus4.rise_tick), 1);
    tick();
    chk("t2_pend_b", 32'(bus4.pend), 1);
    chk("t2_clk_old", 32'(bus4.clk_div), 1);
    chk("t2_po", 32'(bus4.po_cnt), 1);
    chk("t2_ph_bnd", 32'(dut4.ph_cnt_q), 3);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("t2_clk_div", 32'(bus4.clk_div), 32'(c % 5 >= 2));
      chk("t2_rise", 32'(bus4.rise_tick), 32'(c % 5 == 2));
      chk("t2_pend", 32'(bus4.pend), 0);
      tick();
    end

    // 3: load 1 then 0 before boundary, both clamp to 2
    bus4.load = 1'b1; bus4.div_ratio = 4'd1;
    tick();
    bus4.div_ratio = 4'd0;
    chk("t3_pend_a", 32'(bus4.pend), 1);
    tick();
    bus4.load = 1'b0;
    chk("t3_pend_b", 32'(bus4.pend), 1);
    tick();
    tick();
    chk("t3_pend_c", 32'(bus4.pend), 1);
    tick();
    chk("t3_pend_clr", 32'(bus4.pend), 0);
    chk("t3_ratio", 32'(dut4.n_q), 2);
    for (int c = 0; c < 8; c++) begin
      chk("t3_clk_div", 32'(bus4.clk_div), 32'(c % 2));
      chk("t3_rise", 32'(bus4.rise_tick), 32'(c % 2 == 1));
      tick();
    end
    chk("t3_po_wrap", 32'(bus4.po_cnt), 0);

    // 4: move to N=6, then park at ph_cnt=2 with 3 pending
    bus4.load = 1'b1; bus4.div_ratio = 4'd6;
    tick();
    bus4.load = 1'b0;
    chk("t4_pend6", 32'(bus4.pend), 1);
    chk("t4_rise_n2", 32'(bus4.rise_tick), 1);
    tick();
    chk("t4_ratio6", 32'(dut4.n_q), 6);
    chk("t4_po_a", 32'(bus4.po_cnt), 1);
    tick();
    bus4.load = 1'b1; bus4.div_ratio = 4'd3;
    tick();
    bus4.load = 1'b0;
    chk("t4_pend3", 32'(bus4.pend), 1);
    chk("t4_ph2", 32'(dut4.ph_cnt_q), 2);
    chk("t4_clk_lo", 32'(bus4.clk_div), 0);
    bus4.en = 1'b0;
    tick();
    chk("t4_park_ph", 32'(dut4.ph_cnt_q), 0);
    chk("t4_park_clk", 32'(bus4.clk_div), 0);
    chk("t4_park_rise", 32'(bus4.rise_tick), 0);
    chk("t4_park_ratio", 32'(dut4.n_q), 3);
    chk("t4_park_pend", 32'(bus4.pend), 0);
    chk("t4_park_po", 32'(bus4.po_cnt), 1);
    tick();
    chk("t4_hold_po", 32'(bus4.po_cnt), 1);
    chk("t4_hold_clk", 32'(bus4.clk_div), 0);
    bus4.en = 1'b1;
    tick();
    chk("t4_first_rise", 32'(bus4.rise_tick), 1);
    chk("t4_first_clk", 32'(bus4.clk_div), 1);
    tick();
    chk("t4_rise_off", 32'(bus4.rise_tick), 0);
    chk("t4_clk_hi2", 32'(bus4.clk_div), 1);
    chk("t4_po_b", 32'(bus4.po_cnt), 2);
    tick();
    chk("t4_clk_wrap", 32'(bus4.clk_div), 0);
    bus4.load = 1'b1; bus4.div_ratio = 4'd7;
    tick();
    bus4.load = 1'b0;
    chk("t5_pre_pend", 32'(bus4.pend), 1);
    chk("t5_pre_clk", 32'(bus4.clk_div), 1);

    // 5: short async reset pulse in the high phase with a load pending
    #2 rst_n = 1'b0;
    #1;
    chk("t5_clk_div", 32'(bus4.clk_div), 0);
    chk("t5_rise", 32'(bus4.rise_tick), 0);
    chk("t5_po", 32'(bus4.po_cnt), 0);
    chk("t5_pend", 32'(bus4.pend), 0);
    chk("t5_ratio", 32'(dut4.n_q), 4);
    chk("t5_ph", 32'(dut4.ph_cnt_q), 0);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t5_clk_div_n4", 32'(bus4.clk_div), 32'(c % 4 >= 2));
      chk("t5_rise_n4", 32'(bus4.rise_tick), 32'(c % 4 == 2));
      chk("t5_pend_n4", 32'(bus4.pend), 0);
    end

    // 6: 8-bit instance, N=255, po_cnt wraps at 5
    bus8.load = 1'b1; bus8.div_ratio = 8'd255;
    tick();
    bus8.load = 1'b0;
    chk("t6_pend", 32'(bus8.pend), 1);
    tick();
    chk("t6_pend_clr", 32'(bus8.pend), 0);
    chk("t6_ratio", 32'(dut8.n_q), 255);
    chk("t6_clk0", 32'(bus8.clk_div), 0);
    bus8.en = 1'b1;
    for (int k = 0; k < 7 * 255; k++) begin
      chk("t6_clk_div", 32'(bus8.clk_div), 32'(k % 255 >= 127));
      chk("t6_rise", 32'(bus8.rise_tick), 32'(k % 255 == 127));
      chk("t6_po", 32'(bus8.po_cnt), 32'(((k >= 128) ? ((k - 128) / 255 + 1) : 0) % 6));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
